// File: rtl/req_resp_join.sv
// Response join for the forked accelerator request path.
// Caps in-flight instructions and merges per-cluster responses in order.
module req_resp_join #(
   parameter int NrClusters     = 2,
   parameter int MaxOutstanding = 4,
   parameter int DataWidth      = 64,
   parameter int TransIdWidth   = 3,
   parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     req_valid_i,
   output logic                                     req_ready_o,
   output logic                                     req_valid_o,
   input  logic                                     req_ready_i,
   input  logic [NrClusters-1:0]                    resp_valid_i,
   input  logic [NrClusters-1:0][DataWidth-1:0]     resp_result_i,
   input  logic [NrClusters-1:0][TransIdWidth-1:0]  resp_trans_id_i,
   input  logic [NrClusters-1:0]                    resp_exc_i,
   output logic                                     resp_valid_o,
   output logic [DataWidth-1:0]                     resp_result_o,
   output logic [TransIdWidth-1:0]                  resp_trans_id_o,
   output logic                                     resp_exc_o,
   output logic [CntWidth-1:0]                      outstanding_o,
   output logic                                     mismatch_o
);

   localparam int PtrWidth =
      (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [PtrWidth-1:0] LastPtr =
      PtrWidth'(MaxOutstanding - 1);
   localparam logic [CntWidth-1:0] MaxCnt =
      CntWidth'(MaxOutstanding);

   typedef struct packed {
      logic [DataWidth-1:0]    result;
      logic [TransIdWidth-1:0] trans_id;
      logic                    exc;
   } entry_t;

   entry_t              mem_q    [NrClusters][MaxOutstanding];
   logic [PtrWidth-1:0] wr_ptr_q [NrClusters];
   logic [PtrWidth-1:0] rd_ptr_q [NrClusters];
   logic [CntWidth-1:0] occ_q    [NrClusters];
   logic [CntWidth-1:0] cnt_q;
   logic                mismatch_q;

   entry_t              head     [NrClusters];
   logic [NrClusters-1:0] wr_en;
   logic [NrClusters-1:0] spurious;
   logic                space;
   logic                issue;
   logic                joined;
   logic                id_diff;
   logic                exc_any;

   function automatic logic [PtrWidth-1:0] ptr_inc(
      input logic [PtrWidth-1:0] p
   );
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      space       = (cnt_q < MaxCnt);
      req_valid_o = req_valid_i & space;
      req_ready_o = req_ready_i & space;
      issue       = req_valid_o & req_ready_i;
      for (int c = 0; c < NrClusters; c++) begin
         head[c] = mem_q[c][rd_ptr_q[c]];
      end
      joined  = 1'b1;
      id_diff = 1'b0;
      exc_any = 1'b0;
      wr_en    = '0;
      spurious = '0;
      for (int c = 0; c < NrClusters; c++) begin
         joined  = joined & (occ_q[c] != '0);
         exc_any = exc_any | head[c].exc;
         if (head[c].trans_id != head[0].trans_id) begin
            id_diff = 1'b1;
         end
         // A cluster can never hold more answers than instructions in flight
         if (resp_valid_i[c]) begin
            if (occ_q[c] == cnt_q) spurious[c] = 1'b1;
            else                   wr_en[c]    = 1'b1;
         end
      end
      resp_valid_o    = joined;
      resp_result_o   = joined ? head[0].result   : '0;
      resp_trans_id_o = joined ? head[0].trans_id : '0;
      resp_exc_o      = joined & exc_any;
      outstanding_o   = cnt_q;
      mismatch_o      = mismatch_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int c = 0; c < NrClusters; c++) begin
            if (wr_en[c]) begin
               mem_q[c][wr_ptr_q[c]] <= '{
                  result:   resp_result_i[c],
                  trans_id: resp_trans_id_i[c],
                  exc:      resp_exc_i[c]
               };
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         mismatch_q <= 1'b0;
         for (int c = 0; c < NrClusters; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            occ_q[c]    <= '0;
         end
      end else begin
         for (int c = 0; c < NrClusters; c++) begin
            if (wr_en[c]) wr_ptr_q[c] <= ptr_inc(wr_ptr_q[c]);
            if (joined)   rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
            occ_q[c] <= occ_q[c] + CntWidth'(wr_en[c])
                        - CntWidth'(joined);
         end
         if ((|spurious) || (joined && id_diff)) begin
            mismatch_q <= 1'b1;
         end
         cnt_q <= cnt_q + CntWidth'(issue) - CntWidth'(joined);
      end
   end

endmodule

// File: tb/tb_req_resp_join.sv
// Bench for req_resp_join: vector table plus scoreboarded
// multi-cycle sequences (saturation, skew, overlap, reset).
module tb_req_resp_join;

   logic             clk;
   logic             rst_i;
   logic             req_valid_i, req_ready_i;
   logic             req_ready_o, req_valid_o;
   logic [1:0]       resp_valid_i;
   logic [1:0][63:0] resp_result_i;
   logic [1:0][2:0]  resp_trans_id_i;
   logic [1:0]       resp_exc_i;
   logic             resp_valid_o;
   logic [63:0]      resp_result_o;
   logic [2:0]       resp_trans_id_o;
   logic             resp_exc_o;
   logic [2:0]       outstanding_o;
   logic             mismatch_o;

   req_resp_join dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_valid_o     (req_valid_o),
      .req_ready_i     (req_ready_i),
      .resp_valid_i    (resp_valid_i),
      .resp_result_i   (resp_result_i),
      .resp_trans_id_i (resp_trans_id_i),
      .resp_exc_i      (resp_exc_i),
      .resp_valid_o    (resp_valid_o),
      .resp_result_o   (resp_result_o),
      .resp_trans_id_o (resp_trans_id_o),
      .resp_exc_o      (resp_exc_o),
      .outstanding_o   (outstanding_o),
      .mismatch_o      (mismatch_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic rst, rv, rr;
      logic [1:0] cv;
      logic [2:0] id0, id1;
      logic [63:0] r0;
      logic e0, e1;
      logic x_rdy, x_val;
      logic [2:0] x_cnt;
      logic x_rv;
      logic [63:0] x_res;
      logic [2:0] x_id;
      logic x_exc, x_mis;
   } vec_t;

   typedef struct {
      logic [63:0] r;
      logic [2:0]  id;
      logic        e;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   sb_on = 1'b0;
   vec_t tbl[19];

   function automatic vec_t mk(
      logic rst, logic rv, logic rr, logic [1:0] cv,
      logic [2:0] id0, logic [2:0] id1, logic [63:0] r0,
      logic e0, logic e1, logic x_rdy, logic x_val,
      logic [2:0] x_cnt, logic x_rv, logic [63:0] x_res,
      logic [2:0] x_id, logic x_exc, logic x_mis);
      vec_t v;
      v.rst = rst; v.rv = rv; v.rr = rr; v.cv = cv;
      v.id0 = id0; v.id1 = id1; v.r0 = r0;
      v.e0 = e0; v.e1 = e1;
      v.x_rdy = x_rdy; v.x_val = x_val; v.x_cnt = x_cnt;
      v.x_rv = x_rv; v.x_res = x_res; v.x_id = x_id;
      v.x_exc = x_exc; v.x_mis = x_mis;
      return v;
   endfunction

   task automatic chk(input string n, input logic [127:0] a,
                      input logic [127:0] x);
      checks++;
      if (a !== x) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, a, x);
      end
   endtask

   task automatic clr();
      rst_i           = 1'b0;
      req_valid_i     = 1'b0;
      req_ready_i     = 1'b1;
      resp_valid_i    = '0;
      resp_result_i   = '0;
      resp_trans_id_i = '0;
      resp_exc_i      = '0;
   endtask

   task automatic rsp(input int c, input logic [2:0] id,
                      input logic [63:0] r, input logic e);
      resp_valid_i[c]    = 1'b1;
      resp_trans_id_i[c] = id;
      resp_result_i[c]   = r;
      resp_exc_i[c]      = e;
   endtask

   task automatic expect_resp(input logic [2:0] id,
                              input logic [63:0] r, input logic e);
      exp_t x;
      x.r = r; x.id = id; x.e = e; x.cyc = cyc + 1;
      sb.push_back(x);
   endtask

   task automatic settle();
      exp_t x;
      @(negedge clk);
      if (sb_on) begin
         if (sb.size() != 0 && sb[0].cyc == cyc) begin
            x = sb.pop_front();
            chk($sformatf("join_id%0d_c%0d", x.id, cyc),
                128'({resp_valid_o, resp_result_o,
                      resp_trans_id_o, resp_exc_o}),
                128'({1'b1, x.r, x.id, x.e}));
         end else if (resp_valid_o) begin
            checks++;
            failures++;
            $display("FAIL unexpected_join c%0d: got 1 expected 0",
                     cyc);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
      clr();
   endtask

   task automatic cyc_end();
      settle();
      adv();
   endtask

   task automatic drain(input string n);
      for (int k = 0; k < 20; k++) begin
         if (sb.size() == 0 && outstanding_o == 3'd0) break;
         cyc_end();
      end
      chk(n, 128'({sb.size() == 0, outstanding_o}),
          128'({1'b1, 3'd0}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [74:0] obs, want;

      tbl[0]  = mk(0,1,1,2'b00,0,0,0,     0,0, 1,1,0, 0,0,0,0,0);
      tbl[1]  = mk(0,0,1,2'b00,0,0,0,     0,0, 1,0,1, 0,0,0,0,0);
      tbl[2]  = mk(0,1,0,2'b00,0,0,0,     0,0, 0,1,1, 0,0,0,0,0);
      tbl[3]  = mk(0,0,0,2'b01,2,0,'hA5,  0,0, 0,0,1, 0,0,0,0,0);
      tbl[4]  = mk(0,0,0,2'b00,0,0,0,     0,0, 0,0,1, 0,0,0,0,0);
      tbl[5]  = mk(0,0,0,2'b10,0,2,0,     0,1, 0,0,1, 0,0,0,0,0);
      tbl[6]  = mk(0,0,1,2'b00,0,0,0,     0,0, 1,0,1, 1,'hA5,2,1,0);
      tbl[7]  = mk(0,0,1,2'b00,0,0,0,     0,0, 1,0,0, 0,0,0,0,0);
      tbl[8]  = mk(0,0,1,2'b01,5,0,'h3C,  1,0, 1,0,0, 0,0,0,0,0);
      tbl[9]  = mk(0,0,1,2'b00,0,0,0,     0,0, 1,0,0, 0,0,0,0,1);
      tbl[10] = mk(0,1,1,2'b00,0,0,0,     0,0, 1,1,0, 0,0,0,0,1);
      tbl[11] = mk(1,1,1,2'b10,1,1,'h99,  1,1, 1,1,1, 0,0,0,0,1);
      tbl[12] = mk(0,0,1,2'b00,0,0,0,     0,0, 1,0,0, 0,0,0,0,0);
      tbl[13] = mk(0,1,1,2'b00,0,0,0,     0,0, 1,1,0, 0,0,0,0,0);
      tbl[14] = mk(0,0,1,2'b00,0,0,0,     0,0, 1,0,1, 0,0,0,0,0);
      tbl[15] = mk(0,0,1,2'b11,1,3,'h11,  0,0, 1,0,1, 0,0,0,0,0);
      tbl[16] = mk(0,0,1,2'b00,0,0,0,     0,0, 1,0,1, 1,'h11,1,0,0);
      tbl[17] = mk(0,0,1,2'b00,0,0,0,     0,0, 1,0,0, 0,0,0,0,1);
      tbl[18] = mk(0,0,1,2'b00,0,0,0,     0,0, 1,0,0, 0,0,0,0,1);

      clr();
      rst_i = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      clr();
      req_valid_i = 1'b1;
      settle();
      chk("reset_state",
          128'({resp_valid_o, resp_result_o, resp_trans_id_o,
                resp_exc_o, outstanding_o, mismatch_o,
                req_ready_o, req_valid_o}),
          128'({1'b0, 64'd0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b1, 1'b1}));
      req_valid_i = 1'b0;
      adv();

      for (int i = 0; i < $size(tbl); i++) begin
         rst_i              = tbl[i].rst;
         req_valid_i        = tbl[i].rv;
         req_ready_i        = tbl[i].rr;
         resp_valid_i       = tbl[i].cv;
         resp_trans_id_i[0] = tbl[i].id0;
         resp_trans_id_i[1] = tbl[i].id1;
         resp_result_i[0]   = tbl[i].r0;
         resp_result_i[1]   = ~tbl[i].r0;
         resp_exc_i         = {tbl[i].e1, tbl[i].e0};
         @(negedge clk);
         obs  = {req_ready_o, req_valid_o, outstanding_o,
                 resp_valid_o, resp_result_o, resp_trans_id_o,
                 resp_exc_o, mismatch_o};
         want = {tbl[i].x_rdy, tbl[i].x_val, tbl[i].x_cnt,
                 tbl[i].x_rv, tbl[i].x_res, tbl[i].x_id,
                 tbl[i].x_exc, tbl[i].x_mis};
         chk($sformatf("vec%0d", i), 128'(obs), 128'(want));
         adv();
      end

      rst_i = 1'b1;
      cyc_end();
      sb_on = 1'b1;

      for (int i = 0; i < 4; i++) begin
         req_valid_i = 1'b1;
         cyc_end();
      end
      req_valid_i = 1'b1;
      settle();
      chk("sat_cnt", 128'(outstanding_o), 128'(3'd4));
      chk("sat_gate", 128'({req_ready_o, req_valid_o}), 128'(2'b00));
      adv();
      rsp(0, 3'd0, 64'h100, 1'b0);
      rsp(1, 3'd0, 64'h200, 1'b0);
      expect_resp(3'd0, 64'h100, 1'b0);
      settle();
      chk("sat_rdy_t", 128'(req_ready_o), 128'(1'b0));
      adv();
      settle();
      chk("sat_rdy_t1", 128'(req_ready_o), 128'(1'b0));
      adv();
      settle();
      chk("sat_rdy_t2", 128'({req_ready_o, outstanding_o}),
          128'({1'b1, 3'd3}));
      adv();
      for (int i = 1; i < 4; i++) begin
         rsp(0, 3'(i), 64'h100 + 64'(i), i == 3);
         rsp(1, 3'(i), 64'h200 + 64'(i), 1'b0);
         expect_resp(3'(i), 64'h100 + 64'(i), i == 3);
         cyc_end();
      end
      drain("sat_drain");

      for (int i = 0; i < 3; i++) begin
         req_valid_i = 1'b1;
         cyc_end();
      end
      for (int i = 0; i < 3; i++) begin
         rsp(0, 3'(i), 64'h300 + 64'(i), 1'b0);
         cyc_end();
      end
      for (int i = 0; i < 7; i++) cyc_end();
      settle();
      chk("skew_cnt", 128'(outstanding_o), 128'(3'd3));
      adv();
      for (int i = 0; i < 3; i++) begin
         rsp(1, 3'(i), 64'h9000, i == 1);
         expect_resp(3'(i), 64'h300 + 64'(i), i == 1);
         cyc_end();
      end
      drain("skew_drain");

      for (int i = 0; i < 3; i++) begin
         req_valid_i = 1'b1;
         cyc_end();
      end
      rsp(0, 3'd4, 64'h404, 1'b0);
      rsp(1, 3'd4, 64'h504, 1'b0);
      expect_resp(3'd4, 64'h404, 1'b0);
      cyc_end();
      req_valid_i = 1'b1;
      rsp(0, 3'd5, 64'h405, 1'b0);
      settle();
      chk("sim_before", 128'({outstanding_o, req_ready_o}),
          128'({3'd3, 1'b1}));
      adv();
      rsp(1, 3'd5, 64'h505, 1'b1);
      expect_resp(3'd5, 64'h405, 1'b1);
      settle();
      chk("sim_after", 128'(outstanding_o), 128'(3'd3));
      adv();
      for (int i = 6; i < 8; i++) begin
         rsp(0, 3'(i), 64'h400 + 64'(i), 1'b0);
         rsp(1, 3'(i), 64'h500 + 64'(i), 1'b0);
         expect_resp(3'(i), 64'h400 + 64'(i), 1'b0);
         cyc_end();
      end
      drain("sim_drain");
      chk("no_mis", 128'(mismatch_o), 128'(1'b0));

      for (int i = 0; i < 2; i++) begin
         req_valid_i = 1'b1;
         cyc_end();
      end
      rsp(0, 3'd0, 64'h600, 1'b0);
      cyc_end();
      rst_i = 1'b1;
      rsp(1, 3'd0, 64'h700, 1'b0);
      cyc_end();
      req_valid_i = 1'b1;
      settle();
      chk("rst_mid",
          128'({resp_valid_o, resp_result_o, resp_trans_id_o,
                resp_exc_o, outstanding_o, mismatch_o,
                req_ready_o, req_valid_o}),
          128'({1'b0, 64'd0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b1, 1'b1}));
      adv();
      cyc_end();
      rsp(0, 3'd1, 64'h555, 1'b0);
      rsp(1, 3'd1, 64'h666, 1'b0);
      expect_resp(3'd1, 64'h555, 1'b0);
      cyc_end();
      drain("rst_after");
      chk("rst_after_mis", 128'(mismatch_o), 128'(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
